// File: rtl/ifu_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifu_fetch : instruction fetch stage (valid/ready request, valid response) |
// | Revision  : 1.0                                                           |
// +--------------------------------------------------------------------------+
module ifu_fetch #(
  parameter int                XLEN        = 32,
  parameter logic [XLEN-1:0]   RESET_PC    = 32'h8000_0000,
  parameter int                PATTERN_LEN = 8,
  parameter int                MAX_WAIT    = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [XLEN-1:0]        req_addr,
  input  logic                   resp_valid,
  input  logic [XLEN-1:0]        resp_data,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_inst,
  output logic [XLEN-1:0]        out_pc,
  output logic [PATTERN_LEN-1:0] out_pattern,
  output logic                   halted,
  output logic                   fetch_err
);

  localparam logic [2:0] S_REQ  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_HALT = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [3:0]      WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [XLEN-1:0] EBREAK   = XLEN'(32'h0010_0073);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            drop_q, drop_d;
  logic            halted_q, halted_d;
  logic            err_q, err_d;

  logic w_redir_ok;
  logic w_redir_bad;

  assign w_redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
  assign w_redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);

  assign req_valid   = (state_q == S_REQ);
  assign req_addr    = pc_q;
  assign out_valid   = (state_q == S_HOLD) && !drop_q;
  assign out_inst    = inst_q;
  assign out_pc      = ipc_q;
  assign out_pattern = {inst_q[14:12], inst_q[6:2]};
  assign halted      = halted_q;
  assign fetch_err   = err_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    ipc_d    = ipc_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    halted_d = halted_q;
    err_d    = err_q;
    case (state_q)
      S_REQ: begin
        if (w_redir_bad) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          if (w_redir_ok) pc_d = redirect_target;
          if (req_ready) begin
            state_d = S_WAIT;
            cnt_d   = 4'd0;
            // A request issued alongside a redirect fetches the stale PC.
            drop_d  = w_redir_ok;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (w_redir_bad) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          if (w_redir_ok) pc_d = redirect_target;
          if (resp_valid) begin
            if (drop_q || w_redir_ok) begin
              state_d = S_REQ;
              drop_d  = 1'b0;
            end else begin
              state_d = S_HOLD;
              inst_d  = resp_data;
              ipc_d   = pc_q;
            end
          end else if (cnt_q == WAIT_MAX) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (w_redir_ok) begin
            drop_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (w_redir_bad) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (w_redir_ok) begin
          // Redirect beats a simultaneous handshake; no sequential advance.
          pc_d    = redirect_target;
          state_d = S_REQ;
        end else if (out_valid && out_ready) begin
          if (inst_q == EBREAK) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d    = pc_q + XLEN'(4);
            state_d = S_REQ;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      inst_q   <= '0;
      ipc_q    <= '0;
      cnt_q    <= 4'd0;
      drop_q   <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      ipc_q    <= ipc_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// Self-checking bench for ifu_fetch: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
  localparam int          MAXW   = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid, out_ready;
  logic [31:0] out_inst, out_pc;
  logic [7:0]  out_pattern;
  logic        halted, fetch_err;

  int checks = 0;
  int errors = 0;

  ifu_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_pattern(out_pattern),
    .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase 0 = wants to issue, 1 = awaiting data,
  // 2 = presenting an instruction, 3 = halted, 4 = errored.
  int          m_phase;
  logic [31:0] m_pc, m_inst, m_ipc;
  int          m_age;
  bit          m_squash, m_halted, m_err;

  task automatic model_reset();
    m_phase = 0; m_pc = RST_PC; m_inst = 0; m_ipc = 0;
    m_age = 0; m_squash = 0; m_halted = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit live, jump, bad;
    live = (m_phase <= 2);
    jump = live && redirect_valid;
    bad  = jump && (redirect_target % 4 != 0);
    if (bad) begin
      m_phase = 4; m_err = 1;
    end else begin
      case (m_phase)
        0: if (req_ready) begin
             m_phase = 1; m_age = 0; m_squash = jump;
           end
        1: if (resp_valid) begin
             if (m_squash || jump) begin
               m_phase = 0; m_squash = 0;
             end else begin
               m_phase = 2; m_inst = resp_data; m_ipc = m_pc;
             end
           end else if (m_age == MAXW) begin
             m_phase = 4; m_err = 1;
           end else begin
             m_age++;
             if (jump) m_squash = 1;
           end
        2: if (jump) m_phase = 0;
           else if (out_ready) begin
             if (m_inst == EBRK) begin m_phase = 3; m_halted = 1; end
             else begin m_phase = 0; m_pc = m_pc + 4; end
           end
        default: ;
      endcase
      if (jump) m_pc = redirect_target;
    end
  endtask

  task automatic compare_all();
    chk("req_valid", 32'(req_valid), 32'(m_phase == 0));
    chk("req_addr",  req_addr, m_pc);
    chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
    chk("out_inst",  out_inst, m_inst);
    chk("out_pc",    out_pc, m_ipc);
    chk("out_pattern", 32'(out_pattern), 32'({m_inst[14:12], m_inst[6:2]}));
    chk("halted",    32'(halted), 32'(m_halted));
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_ready = 0; resp_valid = 0; resp_data = 0;
    redirect_valid = 0; redirect_target = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    idle_inputs();
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // Issue one request and return data in the first WAIT cycle; ends in HOLD.
  task automatic fetch(input logic [31:0] word);
    req_ready = 1; resp_valid = 0;
    cycle();
    req_ready = 0; resp_valid = 1; resp_data = word;
    cycle();
    resp_valid = 0;
  endtask

  int k;
  int term_cnt;
  logic [31:0] r;

  initial begin
    idle_inputs();
    model_reset();
    do_reset();

    // Reset state
    chk("rst_req_valid", 32'(req_valid), 32'd1);
    chk("rst_req_addr", req_addr, RST_PC);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_flags", {30'd0, halted, fetch_err}, 32'd0);

    // Straight-line fetch
    out_ready = 0;
    fetch(32'h0000_0297);
    chk("sl_valid0", 32'(out_valid), 32'd1);
    chk("sl_pc0", out_pc, 32'h8000_0000);
    chk("sl_pat0", 32'(out_pattern), 32'h05);
    out_ready = 1;
    cycle();
    chk("sl_addr1", req_addr, 32'h8000_0004);
    fetch(32'h0000_0513);
    chk("sl_pc1", out_pc, 32'h8000_0004);
    chk("sl_pat1", 32'(out_pattern), 32'h04);
    cycle();

    // Backpressure
    out_ready = 0;
    fetch(32'h0000_006F);
    for (int i = 0; i < 5; i++) begin
      chk("bp_inst", out_inst, 32'h0000_006F);
      chk("bp_pc", out_pc, 32'h8000_0008);
      chk("bp_pat", 32'(out_pattern), 32'h1B);
      chk("bp_noreq", 32'(req_valid), 32'd0);
      cycle();
    end
    out_ready = 1;
    cycle();
    chk("bp_next", req_addr, 32'h8000_000C);

    // Redirect in WAIT, response two cycles later
    req_ready = 1;
    cycle();
    req_ready = 0; redirect_valid = 1; redirect_target = 32'h8000_0100;
    cycle();
    redirect_valid = 0;
    cycle();
    resp_valid = 1; resp_data = 32'h0000_0013;
    chk("rw_noout", 32'(out_valid), 32'd0);
    cycle();
    resp_valid = 0;
    chk("rw_noout2", 32'(out_valid), 32'd0);
    chk("rw_req", 32'(req_valid), 32'd1);
    chk("rw_addr", req_addr, 32'h8000_0100);

    // Redirect coincident with out handshake
    fetch(32'h0000_0013);
    out_ready = 1; redirect_valid = 1; redirect_target = 32'h8000_0040;
    cycle();
    redirect_valid = 0;
    chk("rh_addr", req_addr, 32'h8000_0040);

    // EBREAK
    out_ready = 0;
    fetch(EBRK);
    chk("eb_pat", 32'(out_pattern), 32'h1C);
    chk("eb_nohalt", 32'(halted), 32'd0);
    out_ready = 1;
    cycle();
    chk("eb_halt", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      req_ready = 1; redirect_valid = (i == 3); redirect_target = 32'h8000_0200;
      chk("eb_noreq", 32'(req_valid), 32'd0);
      cycle();
    end
    redirect_valid = 0;

    // Timeout
    do_reset();
    req_ready = 1;
    cycle();
    req_ready = 0;
    k = 0;
    while (!fetch_err && k < 40) begin
      cycle();
      k++;
    end
    chk("to_latency", 32'(k), 32'(MAXW + 1));
    do_reset();
    chk("to_clr_err", 32'(fetch_err), 32'd0);
    chk("to_clr_addr", req_addr, RST_PC);

    // Misaligned redirect
    redirect_valid = 1; redirect_target = 32'h8000_0002;
    cycle();
    redirect_valid = 0;
    chk("mis_err", 32'(fetch_err), 32'd1);
    chk("mis_noreq", 32'(req_valid), 32'd0);

    // Reset mid-transaction, stale response after release
    do_reset();
    req_ready = 1;
    cycle();
    do_reset();
    resp_valid = 1; resp_data = 32'h0000_0013;
    cycle();
    resp_valid = 0;
    chk("rm_noout", 32'(out_valid), 32'd0);
    chk("rm_req", 32'(req_valid), 32'd1);

    // Randomized traffic
    do_reset();
    term_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      req_ready  = ($urandom_range(0, 9) < 7);
      resp_valid = (m_phase == 1) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 9) == 0);
      resp_data  = ($urandom_range(0, 24) == 0) ? EBRK : $urandom;
      redirect_valid = ($urandom_range(0, 19) == 0);
      r = $urandom;
      redirect_target = ($urandom_range(0, 9) == 0) ? r : {r[31:2], 2'b00};
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (m_phase >= 3) term_cnt++;
      if (term_cnt > 4 || $urandom_range(0, 299) == 0) begin
        do_reset();
        term_cnt = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
